// File: rtl/sfu_pkg.sv
// Shared definitions for the SFU bank sequencer: state encoding, SIMD mode
// constants and default counter/address widths.
package sfu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RD,
        S_DRAIN,
        S_RELU,
        S_WB,
        S_FIN
    } state_t;

    localparam logic MODE_4B = 1'b0;
    localparam logic MODE_2B = 1'b1;

    localparam int CNT_BW_DEF  = 8;
    localparam int ADDR_BW_DEF = 11;

endpackage

// File: rtl/sfu_seq.sv
// Sequencer for the per-column SFU bank: clear, stream n_kij psum words with
// aligned acc pulses, one ReLU step, then write the pixel row to output SRAM.
module sfu_seq
    import sfu_pkg::*;
#(
    parameter int col     = 8,
    parameter int addr_bw = ADDR_BW_DEF,
    parameter int cnt_bw  = CNT_BW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode_in,
    input  logic [cnt_bw-1:0]  n_kij,
    input  logic [cnt_bw-1:0]  n_out,
    input  logic               rd_gnt,
    output logic               rd_en,
    output logic [addr_bw-1:0] rd_addr,
    output logic               sfu_clr,
    output logic               acc,
    output logic               relu,
    output logic               mode,
    output logic               wr_en,
    output logic [addr_bw-1:0] wr_addr,
    output logic               busy,
    output logic               done
);

    localparam int W = (addr_bw > cnt_bw) ? addr_bw : cnt_bw;

    state_t              state;
    logic [cnt_bw-1:0]   nk;
    logic [cnt_bw-1:0]   no;
    logic [cnt_bw-1:0]   o;
    logic [cnt_bw-1:0]   kij;
    logic [addr_bw-1:0]  base;
    logic [W-1:0]        no_w;
    logic [W-1:0]        o_w;
    logic [addr_bw-1:0]  no_a;
    logic [addr_bw-1:0]  o_a;

    // Counters are resized onto the address width; the stride add wraps silently.
    assign no_w = W'(no);
    assign o_w  = W'(o);
    assign no_a = no_w[addr_bw-1:0];
    assign o_a  = o_w[addr_bw-1:0];

    assign rd_en   = (state == S_RD) && rd_gnt && !reset;
    assign rd_addr = (state == S_RD) ? base : '0;
    assign sfu_clr = (state == S_CLR);
    assign relu    = (state == S_RELU);
    assign wr_en   = (state == S_WB);
    assign wr_addr = (state == S_WB) ? o_a : '0;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_FIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            mode  <= MODE_4B;
            nk    <= '0;
            no    <= '0;
            o     <= '0;
            kij   <= '0;
            base  <= '0;
            acc   <= 1'b0;
        end else begin
            // SRAM read latency is one cycle, so acc trails the issued read.
            acc <= rd_en;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode  <= mode_in;
                        nk    <= n_kij;
                        no    <= n_out;
                        o     <= '0;
                        state <= (n_kij == '0 || n_out == '0) ? S_FIN : S_CLR;
                    end
                end
                S_CLR: begin
                    kij   <= '0;
                    base  <= o_a;
                    state <= S_RD;
                end
                S_RD: begin
                    if (rd_gnt) begin
                        kij  <= kij + cnt_bw'(1);
                        base <= base + no_a;
                        if (kij == nk - cnt_bw'(1))
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: state <= S_RELU;
                S_RELU:  state <= S_WB;
                S_WB: begin
                    if (o == no - cnt_bw'(1)) begin
                        state <= S_FIN;
                    end else begin
                        o     <= o + cnt_bw'(1);
                        state <= S_CLR;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfu_seq.sv
// Bench for sfu_seq: table-driven and randomized jobs checked against an
// event-level model of the read/accumulate/relu/write schedule.
module tb_sfu_seq;

    localparam int AW = 11;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset, start, mode_in, rd_gnt;
    logic [CW-1:0] n_kij, n_out;
    logic          rd_en, sfu_clr, acc, relu, mode, wr_en, busy, done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          rd_en_b, sfu_clr_b, acc_b, relu_b, mode_b, wr_en_b, busy_b, done_b;
    logic [3:0]    rd_addr_b, wr_addr_b;

    sfu_seq #(.addr_bw(AW), .cnt_bw(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
        .n_kij(n_kij), .n_out(n_out), .rd_gnt(rd_gnt),
        .rd_en(rd_en), .rd_addr(rd_addr), .sfu_clr(sfu_clr), .acc(acc),
        .relu(relu), .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr),
        .busy(busy), .done(done)
    );

    sfu_seq #(.addr_bw(4), .cnt_bw(CW)) dut16 (
        .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
        .n_kij(n_kij), .n_out(n_out), .rd_gnt(rd_gnt),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .sfu_clr(sfu_clr_b), .acc(acc_b),
        .relu(relu_b), .mode(mode_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    bit     pat [0:4095];
    longint act_rd[$], act_rdb[$], act_acc[$], act_clr[$], act_relu[$], act_wr[$], act_done[$];
    int     busy_cnt, mode_bad, excl_bad, b_bad;
    logic   exp_mode;
    bit     mon_en = 0;
    logic signed [7:0] lo, hi;
    logic [15:0] last_word;

    function automatic longint ev(int c, int a);
        return longint'(c) * 100000 + longint'(a);
    endfunction

    // Passive observer; also a two-lane SFU model fed (+5, -9) per acc.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en)   act_rd.push_back(ev(cyc, int'(rd_addr)));
            if (rd_en_b) act_rdb.push_back(ev(cyc, int'(rd_addr_b)));
            if (acc)     act_acc.push_back(ev(cyc, 0));
            if (sfu_clr) act_clr.push_back(ev(cyc, 0));
            if (relu)    act_relu.push_back(ev(cyc, 0));
            if (wr_en)   act_wr.push_back(ev(cyc, int'(wr_addr)));
            if (done)    act_done.push_back(ev(cyc, 0));
            if (busy) begin
                busy_cnt++;
                if (mode !== exp_mode) mode_bad++;
            end
            if (int'(acc) + int'(relu) + int'(sfu_clr) > 1) excl_bad++;
            if ({rd_en, acc, sfu_clr, relu, wr_en, busy, done, mode} !==
                {rd_en_b, acc_b, sfu_clr_b, relu_b, wr_en_b, busy_b, done_b, mode_b}) b_bad++;
            if (sfu_clr) begin lo = 8'sd0; hi = 8'sd0; end
            if (acc)     begin lo = lo + 8'sd5; hi = hi - 8'sd9; end
            if (relu)    begin if (lo < 0) lo = 8'sd0; if (hi < 0) hi = 8'sd0; end
            if (wr_en)   last_word = {hi, lo};
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input longint a[$], input longint e[$]);
        bit ok;
        int bad;
        tests++;
        ok  = (a.size() == e.size());
        bad = -1;
        for (int i = 0; i < e.size() && i < a.size(); i++)
            if (bad < 0 && a[i] != e[i]) begin ok = 0; bad = i; end
        if (!ok) begin
            fails++;
            if (bad >= 0)
                $display("FAIL %s: event %0d got %0d, expected %0d (cycle*100000+addr)",
                         name, bad, a[bad], e[bad]);
            else
                $display("FAIL %s: got %0d events, expected %0d", name, a.size(), e.size());
        end
    endtask

    task automatic clear_obs(input logic m);
        act_rd.delete(); act_rdb.delete(); act_acc.delete(); act_clr.delete();
        act_relu.delete(); act_wr.delete(); act_done.delete();
        busy_cnt = 0; mode_bad = 0; excl_bad = 0; b_bad = 0;
        exp_mode = m;
    endtask

    // gk: 0 = grant always, 1 = random grant, 2 = grant low for cycles 5..7 after start
    task automatic run_job(input bit m, input int nk, input int no, input int gk,
                           input int lat, input string tag);
        longint e_rd[$], e_rdb[$], e_acc[$], e_clr[$], e_relu[$], e_wr[$], e_done[$];
        int s, t, k, r, edone;
        for (int i = 0; i < 4096; i++)
            pat[i] = (gk == 0) ? 1'b1 : (gk == 1) ? ($urandom_range(0, 9) < 7) : !(i >= 5 && i <= 7);
        clear_obs(m);
        @(posedge clk); #1;
        s = cyc; start = 1; mode_in = m; n_kij = CW'(nk); n_out = CW'(no); rd_gnt = pat[0];
        mon_en = 1;
        r = 0;
        while (act_done.size() == 0 && r < 3000) begin
            @(posedge clk); #1;
            r++; start = 0; rd_gnt = pat[r];
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        mon_en = 0;
        rd_gnt = 1;

        // Schedule: pixel o reads psum k at k*no+o, one per granted cycle.
        t = s + 1;
        if (nk == 0 || no == 0) begin
            edone = s + 1;
        end else begin
            for (int o = 0; o < no; o++) begin
                e_clr.push_back(ev(t, 0)); t++;
                k = 0;
                while (k < nk) begin
                    if (pat[t - s]) begin
                        e_rd.push_back(ev(t, (k * no + o) % 2048));
                        e_rdb.push_back(ev(t, (k * no + o) % 16));
                        e_acc.push_back(ev(t + 1, 0));
                        k++;
                    end
                    t++;
                end
                t++;
                e_relu.push_back(ev(t, 0)); t++;
                e_wr.push_back(ev(t, o)); t++;
            end
            edone = t;
        end
        e_done.push_back(ev(edone, 0));

        chk_q({tag, "_rd"},   act_rd,   e_rd);
        chk_q({tag, "_rd16"}, act_rdb,  e_rdb);
        chk_q({tag, "_acc"},  act_acc,  e_acc);
        chk_q({tag, "_clr"},  act_clr,  e_clr);
        chk_q({tag, "_relu"}, act_relu, e_relu);
        chk_q({tag, "_wr"},   act_wr,   e_wr);
        chk_q({tag, "_done"}, act_done, e_done);
        chk({tag, "_busy_cycles"}, busy_cnt, edone - s);
        chk({tag, "_mode_bad"}, mode_bad, 0);
        chk({tag, "_excl_bad"}, excl_bad, 0);
        chk({tag, "_w16_ctrl_bad"}, b_bad, 0);
        if (lat >= 0)
            chk({tag, "_latency"}, (act_done.size() > 0) ? (act_done[0] / 100000 - s) : -1, lat);
    endtask

    typedef struct {
        bit m;
        int nk;
        int no;
        int gk;
        int lat;
    } vec_t;

    vec_t vt[7];

    initial begin
        int s, a0, a1, a2;
        vt[0] = '{1'b0, 9, 2, 0, 27};
        vt[1] = '{1'b0, 9, 2, 2, 30};
        vt[2] = '{1'b1, 3, 1, 0, 8};
        vt[3] = '{1'b0, 0, 2, 0, 1};
        vt[4] = '{1'b1, 4, 0, 0, 1};
        vt[5] = '{1'b0, 3, 7, 0, 50};
        vt[6] = '{1'b0, 1, 1, 0, 6};

        reset = 1; start = 0; mode_in = 0; rd_gnt = 1; n_kij = '0; n_out = '0;
        lo = 8'sd0; hi = 8'sd0; last_word = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {rd_en, acc, sfu_clr, relu, mode, wr_en, busy, done, rd_addr, wr_addr}, 0);
        chk("reset_outs_w16", {rd_en_b, acc_b, sfu_clr_b, relu_b, mode_b, wr_en_b, busy_b, done_b,
                               rd_addr_b, wr_addr_b}, 0);
        @(posedge clk); #1; reset = 0;

        for (int i = 0; i < 7; i++) begin
            run_job(vt[i].m, vt[i].nk, vt[i].no, vt[i].gk, vt[i].lat, $sformatf("vec%0d", i));
            if (i == 2) begin
                chk("sfu_word_2b", last_word, 16'h000F);
                chk("mode_hold_idle", mode, 1);
            end
            if (i == 5) begin
                if (act_rdb.size() == 21) begin
                    a0 = int'(act_rdb[18] % 100000);
                    a1 = int'(act_rdb[19] % 100000);
                    a2 = int'(act_rdb[20] % 100000);
                end else begin
                    a0 = -1; a1 = 0; a2 = 0;
                end
                chk("wrap_pixel6", a0 * 10000 + a1 * 100 + a2, 61304);
            end
        end

        // Start held across the done cycle: only the IDLE-cycle requests count.
        clear_obs(1'b0);
        @(posedge clk); #1;
        s = cyc; start = 1; mode_in = 0; n_kij = '0; n_out = CW'(3); mon_en = 1;
        repeat (3) begin @(posedge clk); #1; end
        start = 0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1; mon_en = 0;
        chk_q("start_in_done", act_done, '{ev(s + 1, 0), ev(s + 3, 0)});

        // Reset during pixel 1 reads: outputs clear next cycle, no done.
        clear_obs(1'b1);
        @(posedge clk); #1;
        s = cyc; start = 1; mode_in = 1; n_kij = CW'(9); n_out = CW'(2); rd_gnt = 1; mon_en = 1;
        repeat (17) begin @(posedge clk); #1; start = 0; end
        chk("pre_reset_in_rd", {rd_en, busy}, 2'b11);
        reset = 1;
        @(posedge clk); #1; reset = 0;
        @(negedge clk);
        chk("reset_mid_outs", {rd_en, acc, sfu_clr, relu, mode, wr_en, busy, done, rd_addr, wr_addr}, 0);
        repeat (30) @(posedge clk);
        @(negedge clk); #1; mon_en = 0;
        chk("reset_mid_no_done", act_done.size(), 0);
        run_job(1'b0, 9, 2, 0, 27, "after_reset");

        for (int i = 0; i < 15; i++)
            run_job(1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 5), 1, -1,
                    $sformatf("rnd%0d", i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sfu_seq.md
# sfu_seq

Sequencer for the per-column SFU bank (accumulate + ReLU, 4-bit or 2-bit SIMD mode). For each output pixel it clears the SFUs, streams `n_kij` partial-sum words from the psum SRAM into them with aligned `acc` pulses, applies one ReLU step, and writes the result row to the output SRAM. It sits between the core controller (start/done) and the SFU bank plus its two memories, and owns the SFU `acc`/`relu`/`mode` controls for the whole job.

## Interface
- `col`, 8, number of SFU columns driven in lock-step (fan-out only, no per-column state)
- `addr_bw`, 11, psum / output SRAM address width
- `cnt_bw`, 8, width of `n_kij` / `n_out` job counters
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `start`  in  1  one-cycle job request; sampled only in IDLE
- `mode_in`  in  1  0 = 4-bit, 1 = 2-bit SIMD; latched at accepted `start`
- `n_kij`  in  cnt_bw  psum words per output pixel; latched at `start`
- `n_out`  in  cnt_bw  output pixels per job; latched at `start`
- `rd_gnt`  in  1  psum SRAM read grant (shared port); read issues only when high
- `rd_en`  out  1  psum SRAM read strobe
- `rd_addr`  out  addr_bw  psum SRAM address = kij*n_out + o (mod 2^addr_bw)
- `sfu_clr`  out  1  synchronous clear to SFU bank
- `acc`  out  1  SFU accumulate, aligned with read data
- `relu`  out  1  SFU ReLU step
- `mode`  out  1  latched mode to SFU bank, stable for the whole job
- `wr_en`  out  1  output SRAM write strobe (data = SFU `out` bus, not routed here)
- `wr_addr`  out  addr_bw  output address = o
- `busy`  out  1  high from accepted `start` until the `done` cycle inclusive
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLR, RD, DRAIN, RELU, WB, FIN.
- IDLE: `start`=1 latches `mode_in`, `n_kij`, `n_out`, sets o=0; if `n_kij`==0 or `n_out`==0 -> FIN, else -> CLR. `start` outside IDLE ignored.
- CLR: `sfu_clr`=1 for one cycle, kij=0, base=o -> RD.
- RD: `rd_en` = `rd_gnt`, `rd_addr` = base. On issued read: kij++, base += n_out. When the read with kij==n_kij-1 issues -> DRAIN. `rd_gnt`=0 stalls in RD with no read and no kij change.
- `acc` = `rd_en` delayed one register (SRAM read latency 1); asserted in RD and DRAIN cycles following each issued read, never otherwise.
- DRAIN: absorbs last `acc` -> RELU.
- RELU: `relu`=1 one cycle -> WB.
- WB: `wr_en`=1, `wr_addr`=o; if o==n_out-1 -> FIN, else o++ -> CLR.
- FIN: `done`=1 one cycle -> IDLE.
- Address arithmetic: base is a running addr_bw-bit adder (no multiplier); overflow wraps modulo 2^addr_bw silently.
- `acc`, `relu`, `sfu_clr` mutually exclusive in every cycle.
- `mode` updates only on accepted `start`; holds value in IDLE.

## Timing
- Reset: state IDLE; all outputs 0, including `mode`, addresses, counters.
- `reset` mid-job: next cycle IDLE, all outputs 0; no `done`; in-flight read discarded (`acc` forced 0).
- Per pixel, no stalls: 1 (CLR) + n_kij (RD) + 1 (DRAIN) + 1 (RELU) + 1 (WB) = n_kij+4 cycles.
- Job latency: `start` cycle -> `done` = n_out*(n_kij+4) + 1 cycles after `start` (plus stall cycles).
- Read issued at cycle t -> `acc` at t+1; stalls insert gaps in `acc`, order preserved.
- `start` in the `done` cycle is ignored; accepted the following cycle.

## Structure
- Shared package `sfu_pkg`: state encoding enum, `MODE_4B`=0 / `MODE_2B`=1 constants, default `cnt_bw`/`addr_bw`.
- Single module; no sub-module needed (address generator is a few registers inline).

## Test plan
- n_kij=9, n_out=2, rd_gnt=1: reads at addresses 0,2,4,…,16 then 1,3,…,17; 9 `acc` per pixel; `wr_addr` 0 then 1; `done` 27 cycles after `start`.
- Same job, rd_gnt low 3 cycles mid-pixel: same address sequence, `acc` has 3-cycle gap, `done` delayed by exactly 3.
- mode_in=1 with n_kij=3, n_out=1: `mode`=1 throughout, drops only on reset; with SFU model fed lo/hi lanes (+5,−9)×3, written word = {0x00, 0x0F}.
- n_out=0 or n_kij=0: `done` one cycle after `start`, no `rd_en`/`wr_en`/`acc`.
- `reset` asserted during RD of pixel 1: next cycle all outputs 0, no `done`; fresh `start` runs a correct full job.
- base wrap: addr_bw=4, n_kij=3, n_out=7, o=6: addresses 6,13,4 (20 mod 16).
